// File: rtl/control_barrera.sv
// control_barrera: entry barrier and occupancy controller for the parking lot.
// It consumes the one-cycle entra/sale/error pulses from the car sensor FSM and
// keeps the car count. It opens the barrier on a new driver request when a space
// is free. It closes the barrier when a car passes or when the open timer expires.
// Anomalies raise a sticky alarm that stays set until the operator clears it.
//
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous, active-low reset
//   pedido     driver request button (level); only its rising edge counts
//   entra      1-cycle pulse: car entered
//   sale       1-cycle pulse: car left
//   error      1-cycle pulse: invalid sensor sequence
//   ack        operator alarm clear
//   barrera    1 = barrier open (registered)
//   lleno      1 = lot full (registered)
//   ocupacion  current car count (registered)
//   alarma     sticky anomaly flag (registered)
module control_barrera #(
  parameter int CAPACIDAD = 8,
  parameter int ANCHO_CNT = 4,
  parameter int T_ABIERTA = 250,
  parameter int ANCHO_TMR = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pedido,
  input  logic                 entra,
  input  logic                 sale,
  input  logic                 error,
  input  logic                 ack,
  output logic                 barrera,
  output logic                 lleno,
  output logic [ANCHO_CNT-1:0] ocupacion,
  output logic                 alarma
);

  localparam logic [ANCHO_CNT-1:0] CAP_W    = ANCHO_CNT'(CAPACIDAD);
  localparam logic [ANCHO_TMR-1:0] TMR_INIT = ANCHO_TMR'(T_ABIERTA - 1);

  typedef enum logic {CERRADA, ABIERTA} estado_t;

  estado_t              state, state_next;
  logic [ANCHO_TMR-1:0] timer, timer_next;
  logic                 pedido_r;
  logic                 request;
  logic [ANCHO_CNT-1:0] ocup_next;
  logic                 set_alarma;

  assign request = pedido & ~pedido_r;

  // Barrier FSM: next state and open timer.
  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      CERRADA: begin
        if (request && !lleno) begin
          state_next = ABIERTA;
          timer_next = TMR_INIT;
        end
      end
      ABIERTA: begin
        // A car passing in the same cycle the timer hits 0 counts as a
        // passage; the entra branch takes priority.
        if (entra)
          state_next = CERRADA;
        else if (timer == '0)
          state_next = CERRADA;
        else
          timer_next = timer - 1'b1;
      end
      default: state_next = CERRADA;
    endcase
  end

  // Occupancy update and alarm sources. A tailgater (entra while closed) is
  // still counted.
  always_comb begin
    ocup_next  = ocupacion;
    set_alarma = error | (entra & (state == CERRADA));
    if (entra && !sale) begin
      if (ocupacion < CAP_W)
        ocup_next = ocupacion + 1'b1;
      else
        set_alarma = 1'b1;
    end else if (sale && !entra) begin
      if (ocupacion != '0)
        ocup_next = ocupacion - 1'b1;
      else
        set_alarma = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CERRADA;
      timer     <= '0;
      pedido_r  <= 1'b0;
      barrera   <= 1'b0;
      lleno     <= 1'b0;
      ocupacion <= '0;
      alarma    <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      pedido_r  <= pedido;
      barrera   <= (state_next == ABIERTA);
      ocupacion <= ocup_next;
      lleno     <= (ocup_next == CAP_W);
      // Setting the alarm wins over clearing it.
      if (set_alarma)
        alarma <= 1'b1;
      else if (ack)
        alarma <= 1'b0;
    end
  end

endmodule

// File: tb/tb_control_barrera.sv
// tb_control_barrera: directed bench for control_barrera with CAPACIDAD=2 and
// T_ABIERTA=5. Inputs change 1 ns after a rising edge. Outputs are checked at the
// same point, so each check sees the result of the edge just taken.
module tb_control_barrera;

  logic       clk = 1'b0;
  logic       reset, pedido, entra, sale, error, ack;
  logic       barrera, lleno, alarma;
  logic [3:0] ocupacion;

  int checks   = 0;
  int failures = 0;

  control_barrera #(
    .CAPACIDAD(2),
    .ANCHO_CNT(4),
    .T_ABIERTA(5),
    .ANCHO_TMR(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pedido    (pedido),
    .entra     (entra),
    .sale      (sale),
    .error     (error),
    .ack       (ack),
    .barrera   (barrera),
    .lleno     (lleno),
    .ocupacion (ocupacion),
    .alarma    (alarma)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int b, input int l,
                         input int o, input int a);
    chk({tag, ".barrera"},   int'(barrera),   b);
    chk({tag, ".lleno"},     int'(lleno),     l);
    chk({tag, ".ocupacion"}, int'(ocupacion), o);
    chk({tag, ".alarma"},    int'(alarma),    a);
  endtask

  initial begin
    reset = 1'b0; pedido = 1'b0; entra = 1'b0; sale = 1'b0;
    error = 1'b0; ack = 1'b0;
    tick(); tick();
    chk_all("reset_init", 0, 0, 0, 0);
    reset = 1'b1;
    tick();

    // 1. Reset mid-run clears everything immediately.
    pedido = 1'b1; tick(); pedido = 1'b0;
    chk("t1_open", int'(barrera), 1);
    entra = 1'b1; tick(); entra = 1'b0;
    chk("t1_count", int'(ocupacion), 1);
    pedido = 1'b1; tick(); pedido = 1'b0;
    chk("t1_reopen", int'(barrera), 1);
    #2 reset = 1'b0;
    #1 chk_all("t1_async_reset", 0, 0, 0, 0);
    tick(); reset = 1'b1; tick();
    chk_all("t1_after_release", 0, 0, 0, 0);

    // 2. Normal entry, entra two cycles after the request edge.
    pedido = 1'b1; tick(); pedido = 1'b0;
    chk("t2_open", int'(barrera), 1);
    tick();
    chk("t2_still_open", int'(barrera), 1);
    entra = 1'b1; tick(); entra = 1'b0;
    chk_all("t2_entered", 0, 0, 1, 0);

    // 3. Timeout after exactly 5 open cycles.
    pedido = 1'b1; tick(); pedido = 1'b0;
    chk("t3_open_c1", int'(barrera), 1);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk($sformatf("t3_open_c%0d", i), int'(barrera), 1);
    end
    tick();
    chk_all("t3_timeout", 0, 0, 1, 0);

    // 4. Full lot blocks requests until a car leaves.
    pedido = 1'b1; tick(); pedido = 1'b0;
    chk("t4_open", int'(barrera), 1);
    entra = 1'b1; tick(); entra = 1'b0;
    chk_all("t4_full", 0, 1, 2, 0);
    pedido = 1'b1; tick(); pedido = 1'b0;
    chk("t4_full_blocked", int'(barrera), 0);
    tick();
    sale = 1'b1; tick(); sale = 1'b0;
    chk_all("t4_sale", 0, 0, 1, 0);
    pedido = 1'b1; tick(); pedido = 1'b0;
    chk("t4_reopen", int'(barrera), 1);
    // A held button does not re-trigger; this entra closes the barrier.
    entra = 1'b1; tick(); entra = 1'b0;
    chk_all("t4_full_again", 0, 1, 2, 0);
    pedido = 1'b1; tick(); tick(); pedido = 1'b0;
    chk("t4_hold_blocked", int'(barrera), 0);

    // 5. Boundaries.
    sale = 1'b1; tick();
    chk("t5_sale1", int'(ocupacion), 1);
    tick(); sale = 1'b0;
    chk_all("t5_sale2", 0, 0, 0, 0);
    sale = 1'b1; tick(); sale = 1'b0;
    chk_all("t5_underflow", 0, 0, 0, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t5_ack", int'(alarma), 0);

    // 6. Tailgater while closed: counted, alarm raised, barrier stays shut.
    entra = 1'b1; tick(); entra = 1'b0;
    chk_all("t6_tailgate", 0, 0, 1, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t6_ack", int'(alarma), 0);

    // 5 (cont). entra and sale together at 1 while open: no change, no alarm.
    pedido = 1'b1; tick(); pedido = 1'b0;
    chk("t5_open", int'(barrera), 1);
    entra = 1'b1; sale = 1'b1; tick(); entra = 1'b0; sale = 1'b0;
    chk_all("t5_entra_sale", 0, 0, 1, 0);
    error = 1'b1; ack = 1'b1; tick(); error = 1'b0;
    chk("t5_error_ack", int'(alarma), 1);
    tick(); ack = 1'b0;
    chk("t5_ack_after", int'(alarma), 0);

    // entra on the same cycle the timer reaches 0: passage, no alarm.
    pedido = 1'b1; tick(); pedido = 1'b0;
    tick(); tick(); tick(); tick();
    chk("tz_open_last", int'(barrera), 1);
    entra = 1'b1; tick(); entra = 1'b0;
    chk_all("tz_entra_at_zero", 0, 1, 2, 0);

    // Overflow: entra at full capacity saturates and alarms.
    entra = 1'b1; tick(); entra = 1'b0;
    chk_all("tz_overflow", 0, 1, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
